max_pool2x2: RTL and testbench

Streaming 2×2 max-pooling stage placed directly downstream of the convolution neurons. It consumes one 8-bit convolution result per kernel per valid cycle, in raster order over an MAP_W×MAP_H feature map. It keeps a half-row line buffer of partial maxima and publishes the complete pooled map for every kernel as one registered, stable array with a one-cycle `pooled_valid` strobe. That array feeds the fully-connected neuron stage.

---
 rtl/pool_pkg.sv | 17 +
 rtl/pool_max2.sv | 24 ++
 rtl/max_pool2x2.sv | 148 ++++++++++++++
 tb/tb_max_pool2x2.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and default geometry for the 2x2 max-pooling stage.
package pool_pkg;

  localparam int unsigned NUM_KERNELS = 2;
  localparam int unsigned MAP_W       = 4;
  localparam int unsigned MAP_H       = 4;
  localparam int unsigned PIXEL_W     = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } pool_state_e;

endpackage

// File: rtl/pool_max2.sv
// Combinational unsigned two-input max. Build option POOL_RELU_EN clamps
// negative (bit7 set) inputs to zero before the compare.
module pool_max2
  import pool_pkg::*;
(
  input  pixel_t a,
  input  pixel_t b,
  output pixel_t max_c
);

  pixel_t a_c;
  pixel_t b_c;

`ifdef POOL_RELU_EN
  assign a_c = a[PIXEL_W-1] ? '0 : a;
  assign b_c = b[PIXEL_W-1] ? '0 : b;
`else
  assign a_c = a;
  assign b_c = b;
`endif

  assign max_c = (a_c >= b_c) ? a_c : b_c;

endmodule

// File: rtl/max_pool2x2.sv
// Streaming 2x2 max-pool over raster-ordered conv results; publishes the
// whole pooled map per frame. Build option POOL_RELU_EN enables input ReLU.
module max_pool2x2 #(
  parameter int unsigned  NUM_KERNELS = pool_pkg::NUM_KERNELS,
  parameter int unsigned  MAP_W       = pool_pkg::MAP_W,
  parameter int unsigned  MAP_H       = pool_pkg::MAP_H,
  localparam int unsigned POOL_N      = (MAP_W / 2) * (MAP_H / 2)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                conv_valid,
  input  logic [NUM_KERNELS-1:0][7:0]         conv_result,
  output logic                                busy,
  output logic                                pooled_valid,
  output logic [NUM_KERNELS-1:0][POOL_N-1:0][7:0] pooled_data,
  output logic                                drop
);

  import pool_pkg::*;

  localparam int unsigned HALF_W = MAP_W / 2;
  localparam int unsigned COL_W  = $clog2(MAP_W);
  localparam int unsigned ROW_W  = $clog2(MAP_H);
  localparam int unsigned HW_W   = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int unsigned IDX_W  = (POOL_N > 1) ? $clog2(POOL_N) : 1;

  pool_state_e state_q, state_d;

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;

  pixel_t pair_q   [NUM_KERNELS];
  pixel_t line_q   [NUM_KERNELS][HALF_W];
  pixel_t shadow_q [NUM_KERNELS][POOL_N];

  logic [NUM_KERNELS-1:0][7:0] max_pair_c;
  logic [NUM_KERNELS-1:0][7:0] max_quad_c;

  logic             accept_c;
  logic             last_c;
  logic [HW_W-1:0]  half_c;
  logic [IDX_W-1:0] idx_c;

  // Element acceptance and pooled-cell addressing
  always_comb begin
    accept_c = (state_q == ACCUM) && conv_valid && !start;
    last_c   = accept_c && (col_q == COL_W'(MAP_W - 1)) && (row_q == ROW_W'(MAP_H - 1));
    half_c   = HW_W'(col_q >> 1);
    idx_c    = IDX_W'((32'(row_q) >> 1) * HALF_W + 32'(half_c));
  end

  // Horizontal pair max, then merge with the partial max from the row above
  for (genvar k = 0; k < NUM_KERNELS; k++) begin : g_kernel
    pool_max2 u_pair (
      .a     (pair_q[k]),
      .b     (conv_result[k]),
      .max_c (max_pair_c[k])
    );
    pool_max2 u_quad (
      .a     (line_q[k][half_c]),
      .b     (max_pair_c[k]),
      .max_c (max_quad_c[k])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ACCUM:   if (last_c) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Raster position counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (start) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept_c) begin
      if (col_q == COL_W'(MAP_W - 1)) begin
        col_q <= '0;
        row_q <= (row_q == ROW_W'(MAP_H - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  // Pair register, line buffer and shadow map
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NUM_KERNELS; k++) begin
        pair_q[k] <= '0;
        for (int unsigned h = 0; h < HALF_W; h++) line_q[k][h]   <= '0;
        for (int unsigned i = 0; i < POOL_N; i++) shadow_q[k][i] <= '0;
      end
    end else if (start) begin
      for (int unsigned k = 0; k < NUM_KERNELS; k++) begin
        pair_q[k] <= '0;
        for (int unsigned h = 0; h < HALF_W; h++) line_q[k][h] <= '0;
      end
    end else if (accept_c) begin
      for (int unsigned k = 0; k < NUM_KERNELS; k++) begin
        if (!col_q[0])      pair_q[k]          <= conv_result[k];
        else if (!row_q[0]) line_q[k][half_c]  <= max_pair_c[k];
        else                shadow_q[k][idx_c] <= max_quad_c[k];
      end
    end
  end

  // Registered outputs; the last cell bypasses the shadow so the map loads in one edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy         <= 1'b0;
      pooled_valid <= 1'b0;
      drop         <= 1'b0;
      pooled_data  <= '0;
    end else begin
      busy         <= (state_d == ACCUM);
      pooled_valid <= (state_d == DONE);
      if (start)                                drop <= 1'b0;
      else if (conv_valid && state_q != ACCUM)  drop <= 1'b1;
      if (last_c) begin
        for (int unsigned k = 0; k < NUM_KERNELS; k++) begin
          for (int unsigned i = 0; i < POOL_N; i++) begin
            pooled_data[k][i] <= (i == POOL_N - 1) ? max_quad_c[k] : shadow_q[k][i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_max_pool2x2.sv
// Scoreboard bench for max_pool2x2: expected pooled maps queued at stimulus
// time, compared whenever pooled_valid strobes.
module tb_max_pool2x2;

  localparam int NK = 2;
  localparam int MW = 4;
  localparam int MH = 4;
  localparam int PN = 4;
  localparam int NE = MW * MH;

  typedef logic [7:0] frame_t [NK][NE];

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       start;
  logic                       conv_valid;
  logic [NK-1:0][7:0]         conv_result;
  logic                       busy;
  logic                       pooled_valid;
  logic [NK-1:0][PN-1:0][7:0] pooled_data;
  logic                       drop;

  int total    = 0;
  int bad      = 0;
  int n_strobe = 0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  max_pool2x2 dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .conv_valid   (conv_valid),
    .conv_result  (conv_result),
    .busy         (busy),
    .pooled_valid (pooled_valid),
    .pooled_data  (pooled_data),
    .drop         (drop)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] clamp(input logic [7:0] v);
`ifdef POOL_RELU_EN
    return v[7] ? 8'h00 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [63:0] model(input frame_t f);
    logic [63:0] r;
    logic [7:0]  m;
    logic [7:0]  v;
    r = '0;
    for (int k = 0; k < NK; k++)
      for (int pr = 0; pr < MH / 2; pr++)
        for (int pc = 0; pc < MW / 2; pc++) begin
          m = 8'h00;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
              v = clamp(f[k][(2 * pr + dr) * MW + 2 * pc + dc]);
              if (v > m) m = v;
            end
          r[(k * PN + pr * (MW / 2) + pc) * 8 +: 8] = m;
        end
    return r;
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin
    if (rst && pooled_valid) begin
      n_strobe++;
      if (exp_q.size() == 0) chk("spurious_strobe", 64'(pooled_valid), 64'(0));
      else                   chk("frame", 64'(pooled_data), exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic with_valid);
    start       = 1'b1;
    conv_valid  = with_valid;
    conv_result = 16'($urandom);
    step();
    start      = 1'b0;
    conv_valid = 1'b0;
  endtask

  task automatic feed(input frame_t f, input int n, input bit gapped);
    for (int i = 0; i < n; i++) begin
      if (gapped) begin
        conv_valid  = 1'b0;
        conv_result = 16'($urandom);
        @(negedge clk);
        chk("gap_busy", 64'(busy), 64'(1));
        step();
      end
      conv_valid  = 1'b1;
      conv_result = {f[1][i], f[0][i]};
      @(negedge clk);
      chk("busy", 64'(busy), 64'(1));
      if (i == n - 1) chk("pv_early", 64'(pooled_valid), 64'(0));
      step();
    end
    conv_valid = 1'b0;
  endtask

  task automatic fill(output frame_t f, input int mode, input logic [7:0] c);
    for (int k = 0; k < NK; k++)
      for (int i = 0; i < NE; i++)
        case (mode)
          0:       f[k][i] = (k == 0) ? 8'(i) : 8'(NE - 1 - i);
          1:       f[k][i] = c;
          default: f[k][i] = 8'($urandom);
        endcase
  endtask

  initial begin
    frame_t fa, fr, fz, fn;
    int n0;
    rst = 1'b0; start = 1'b0; conv_valid = 1'b0; conv_result = '0;

    // Reset with random inputs
    repeat (4) begin
      @(posedge clk); #1;
      start = 1'($urandom); conv_valid = 1'($urandom); conv_result = 16'($urandom);
    end
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_pv",   64'(pooled_valid), 64'(0));
    chk("rst_drop", 64'(drop), 64'(0));
    chk("rst_data", 64'(pooled_data), 64'(0));
    start = 1'b0; conv_valid = 1'b0;
    step();
    rst = 1'b1;
    step(); step();

    // Basic back-to-back frame with exact strobe timing
    fill(fa, 0, 8'h00);
    exp_q.push_back(64'h05_07_0D_0F_0F_0D_07_05);
    do_start(1'b0);
    feed(fa, NE, 1'b0);
    @(negedge clk);
    chk("pv_high", 64'(pooled_valid), 64'(1));
    chk("busy_done", 64'(busy), 64'(0));
    step();
    @(negedge clk);
    chk("pv_one_cycle", 64'(pooled_valid), 64'(0));
    step(); step();

    // Gapped input
    exp_q.push_back(model(fa));
    do_start(1'b0);
    feed(fa, NE, 1'b1);
    repeat (3) step();

    // Restart mid-frame; start collides with a valid element
    fill(fr, 2, 8'h00);
    fill(fz, 1, 8'h22);
    n0 = n_strobe;
    exp_q.push_back({8{8'h22}});
    do_start(1'b0);
    feed(fr, 7, 1'b0);
    do_start(1'b1);
    chk("hold_after_abort", 64'(pooled_data), 64'h05_07_0D_0F_0F_0D_07_05);
    feed(fz, NE - 1, 1'b0);
    chk("hold_before_last", 64'(pooled_data), 64'h05_07_0D_0F_0F_0D_07_05);
    conv_valid = 1'b1; conv_result = {8'h22, 8'h22};
    step();
    conv_valid = 1'b0;
    repeat (3) step();
    chk("restart_strobes", 64'(n_strobe - n0), 64'(1));

    // ReLU clamp on negative bytes
    fill(fn, 1, 8'hF0);
`ifdef POOL_RELU_EN
    exp_q.push_back(64'h0);
`else
    exp_q.push_back({8{8'hF0}});
`endif
    do_start(1'b0);
    feed(fn, NE, 1'b0);
    repeat (3) step();

    // Drop in IDLE, sticky until start; counters must not move
    conv_valid = 1'b1; conv_result = 16'($urandom);
    step();
    conv_valid = 1'b0;
    @(negedge clk);
    chk("drop_set", 64'(drop), 64'(1));
    chk("drop_busy", 64'(busy), 64'(0));
    repeat (3) step();
    @(negedge clk);
    chk("drop_sticky", 64'(drop), 64'(1));
    fill(fr, 2, 8'h00);
    exp_q.push_back(model(fr));
    do_start(1'b0);
    @(negedge clk);
    chk("drop_clear", 64'(drop), 64'(0));
    step();
    feed(fr, NE, 1'b0);
    repeat (3) step();

    // Reset mid-frame
    n0 = n_strobe;
    fill(fn, 2, 8'h00);
    do_start(1'b0);
    feed(fn, 5, 1'b0);
    rst = 1'b0;
    #1;
    chk("mr_busy", 64'(busy), 64'(0));
    chk("mr_data", 64'(pooled_data), 64'(0));
    chk("mr_pv",   64'(pooled_valid), 64'(0));
    step(); step();
    rst = 1'b1;
    repeat (4) step();
    chk("mr_no_strobe", 64'(n_strobe - n0), 64'(0));

    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
